// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain sequencer feeding uart_tx over the
// data/act/busy handshake. Producers may write one byte per cycle; the
// sequencer issues one start pulse per byte and waits for the frame to finish.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_act,
  input  logic          i_tx_busy
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, ovf_q;
  state_t        state_q;
  logic [TW-1:0] to_q;
  logic [7:0]    tx_data_q;
  logic          tx_act_q;
  logic          push, pop;

  // Full is the registered flag, so a write while full is dropped even if a
  // pop happens in the same cycle. Pops only come from an idle sequencer.
  assign push = i_wr_en && !full_q;
  assign pop  = (state_q == S_IDLE) && !empty_q && !i_tx_busy;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Byte storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_q] <= i_wr_data;
  end

  // Pointers, occupancy, registered flags and the sticky overflow bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
      if (i_wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  // Drain sequencer: pop and pulse act, then wait for busy to rise and fall.
  // If busy never rises within the timeout the byte is treated as sent.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      tx_data_q <= 8'h00;
      tx_act_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q <= mem[rd_q];
            tx_act_q  <= 1'b1;
            state_q   <= S_START;
          end
        end
        S_START: begin
          tx_act_q <= 1'b0;
          to_q     <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            to_q <= to_q + TW'(1);
            if (to_q == TO_LAST) state_q <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_act   = tx_act_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart_tx busy model.
module tb_uart_tx_fifo;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_wr_data;
  logic       i_wr_en;
  logic       o_full, o_empty, o_overflow, o_tx_act;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;

  uart_tx_fifo #(.DEPTH(16), .AW(4), .BUSY_TIMEOUT(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_wr_data(i_wr_data),
    .i_wr_en(i_wr_en), .o_full(o_full), .o_empty(o_empty),
    .o_count(o_count), .o_overflow(o_overflow), .o_tx_data(o_tx_data),
    .o_tx_act(o_tx_act), .i_tx_busy(i_tx_busy)
  );

  always #5 i_clock = ~i_clock;

  // Busy source: 0 = model, 1 = forced high, 2 = forced low.
  logic [1:0] mode = 2'd0;
  int         bcnt = 0;
  int         cyc  = 0;
  int         mon_bad = 0;
  logic       prev_act = 1'b0;
  logic [7:0] sent[$];
  int         pcyc[$];

  assign i_tx_busy = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (bcnt != 0);

  always @(posedge i_clock) cyc++;

  // Monitor and busy model: busy rises half a cycle after act, lasts 100 cycles.
  always @(negedge i_clock) begin
    if (o_tx_act) begin
      sent.push_back(o_tx_data);
      pcyc.push_back(cyc);
      if (prev_act) mon_bad++;
      if (mode == 2'd0 && bcnt != 0) mon_bad++;
      bcnt = 100;
    end else if (bcnt > 0) begin
      bcnt--;
    end
    prev_act = o_tx_act;
  end

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    i_wr_en = 1'b1;
    i_wr_data = b;
    tick();
    i_wr_en = 1'b0;
  endtask

  // Wait until n bytes have been sent and everything has drained.
  task automatic drain(input int n, input int bound, input string tag);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      if (sent.size() >= n && !i_tx_busy && o_empty) begin
        done = 1;
        break;
      end
      tick();
    end
    repeat (3) tick();
    chk({tag, "_timeout"}, int'(done), 1);
    chk({tag, "_nsent"}, sent.size(), n);
  endtask

  initial begin
    int base;
    i_reset = 1'b1;
    i_wr_en = 1'b0;
    i_wr_data = 8'h00;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_act", o_tx_act, 0);
    chk("rst_data", o_tx_data, 8'h00);

    // Single byte latency
    i_wr_en = 1'b1; i_wr_data = 8'h48;
    tick();
    i_wr_en = 1'b0;
    chk("lat_k_count", o_count, 1);
    chk("lat_k_empty", o_empty, 0);
    chk("lat_k_act", o_tx_act, 0);
    tick();
    chk("lat_k1_act", o_tx_act, 1);
    chk("lat_k1_data", o_tx_data, 8'h48);
    chk("lat_k1_count", o_count, 0);
    tick();
    chk("lat_k2_act", o_tx_act, 0);
    drain(1, 300, "single");
    chk("single_byte", sent[0], 8'h48);
    chk("single_empty", o_empty, 1);

    // "Hello" burst
    base = sent.size();
    i_wr_en = 1'b1;
    i_wr_data = 8'h48; tick();
    i_wr_data = 8'h65; tick();
    i_wr_data = 8'h6C; tick();
    i_wr_data = 8'h6C; tick();
    i_wr_data = 8'h6F; tick();
    i_wr_en = 1'b0;
    drain(base + 5, 1000, "hello");
    chk("hello_0", sent[base+0], 8'h48);
    chk("hello_1", sent[base+1], 8'h65);
    chk("hello_2", sent[base+2], 8'h6C);
    chk("hello_3", sent[base+3], 8'h6C);
    chk("hello_4", sent[base+4], 8'h6F);
    chk("hello_spacing", mon_bad, 0);

    // Fill while busy held, then overflow
    base = sent.size();
    mode = 2'd1;
    tick();
    i_wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      i_wr_data = 8'(8'h10 + i);
      tick();
    end
    chk("fill_count", o_count, 16);
    chk("fill_full", o_full, 1);
    chk("fill_ovf_pre", o_overflow, 0);
    i_wr_data = 8'h21;
    tick();
    i_wr_en = 1'b0;
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count", o_count, 16);
    chk("ovf_nosend", sent.size(), base);
    mode = 2'd0;
    drain(base + 16, 2500, "fill");
    for (int i = 0; i < 16; i++) chk("fill_order", sent[base+i], 8'h11 + i);
    chk("fill_spacing", mon_bad, 0);

    // Busy never rises: timeout then next byte
    base = sent.size();
    mode = 2'd2;
    wr(8'hAA);
    wr(8'h55);
    drain(base + 2, 100, "tmo");
    chk("tmo_b0", sent[base], 8'hAA);
    chk("tmo_b1", sent[base+1], 8'h55);
    chk("tmo_gap", pcyc[base+1] - pcyc[base], 6);

    // Reset with bytes queued and busy high
    repeat (10) tick();
    base = sent.size();
    mode = 2'd1;
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    chk("rq_count", o_count, 3);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rq_count0", o_count, 0);
    chk("rq_empty", o_empty, 1);
    chk("rq_full", o_full, 0);
    chk("rq_ovf", o_overflow, 0);
    chk("rq_act", o_tx_act, 0);
    chk("rq_data", o_tx_data, 8'h00);
    repeat (5) tick();
    chk("rq_nosend", sent.size(), base);
    mode = 2'd0;
    wr(8'hD7);
    drain(base + 1, 400, "rq");
    chk("rq_new", sent[base], 8'hD7);

    // 40 bytes one at a time, pointers wrap
    base = sent.size();
    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 7 + 3));
      drain(base + i + 1, 300, "wrap");
      chk("wrap_byte", sent[base+i], (i * 7 + 3) & 8'hFF);
    end
    chk("wrap_ovf", o_overflow, 0);
    chk("wrap_empty", o_empty, 1);
    chk("wrap_spacing", mon_bad, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
